// File: rtl/mux_scan_sel.sv
// ============================================================================
// Module      : mux_scan_sel
// Description : Registered N-channel strobed inverting selector with optional
//               auto-scan (enable with MUX_SCAN_SEL_SCAN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_sel #(
    parameter  int CH    = 16,
    parameter  int DW    = 1,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [CH*DW-1:0] e,
    output logic [DW-1:0]    w,
    output logic [SW-1:0]    cur,
    output logic             wrap
);

    localparam int         c_npad      = 1 << SW;
    localparam logic [1:0] c_st_off    = 2'd0;
    localparam logic [1:0] c_st_direct = 2'd1;
`ifdef MUX_SCAN_SEL_SCAN_EN
    localparam logic [1:0] c_st_scan   = 2'd2;
    localparam int         c_dcw       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_dcw-1:0] c_dwell_last = c_dcw'(DWELL - 1);
    localparam logic [SW-1:0]    c_last_ch    = SW'(CH - 1);
`endif

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [SW-1:0] w_nxt;
    logic [DW-1:0] w_data_nxt;
    logic [DW-1:0] r_w;
    logic [SW-1:0] r_cur;
    logic [DW-1:0] w_chn [c_npad];

    // Pre-inverted channel table; unused codes above CH-1 read as all ones
    generate
        for (genvar k = 0; k < c_npad; k++) begin : g_ch
            if (k < CH) begin : g_real
                assign w_chn[k] = ~e[k*DW +: DW];
            end else begin : g_pad
                assign w_chn[k] = '1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_off;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef MUX_SCAN_SEL_SCAN_EN
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [c_dcw-1:0] r_dcnt;
    logic [c_dcw-1:0] w_dcnt_nxt;

    always_comb begin
        w_state_nxt = c_st_direct;
        if (stb) begin
            w_state_nxt = c_st_off;
        end else if (mode) begin
            w_state_nxt = c_st_scan;
        end
    end

    always_comb begin
        w_nxt      = '0;
        w_dcnt_nxt = '0;
        w_wrap_nxt = 1'b0;
        w_data_nxt = '1;
        if (!stb) begin
            if (!mode) begin
                w_nxt = sel;
            end else if (r_state == c_st_scan) begin
                if (r_dcnt != c_dwell_last) begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                    w_nxt      = r_cur;
                end else if (r_cur == c_last_ch) begin
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_nxt = r_cur + 1'b1;
                end
            end
            w_data_nxt = w_chn[w_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_dcnt <= w_dcnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign wrap = r_wrap;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    always_comb begin
        w_state_nxt = stb ? c_st_off : c_st_direct;
    end

    always_comb begin
        w_nxt      = '0;
        w_data_nxt = '1;
        if (!stb) begin
            w_nxt      = sel;
            w_data_nxt = w_chn[w_nxt];
        end
    end

    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w   <= '1;
            r_cur <= '0;
        end else begin
            r_w   <= w_data_nxt;
            r_cur <= w_nxt;
        end
    end

    assign w   = r_w;
    assign cur = r_cur;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
// ============================================================================
// Module      : tb_mux_scan_sel
// Description : Directed self-checking bench for mux_scan_sel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sel;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] e;
    logic [2:0]  sel5;
    logic [9:0]  e5;

    logic [0:0]  w;
    logic [3:0]  cur;
    logic        wrap;
    logic [0:0]  w1;
    logic [3:0]  cur1;
    logic        wrap1;
    logic [1:0]  w5;
    logic [2:0]  cur5;
    logic        wrap5;

    int n_tests;
    int n_fail;

    mux_scan_sel #(.CH(16), .DW(1), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .stb(stb), .mode(mode), .sel(sel), .e(e),
        .w(w), .cur(cur), .wrap(wrap)
    );

    mux_scan_sel #(.CH(16), .DW(1), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stb(stb), .mode(mode), .sel(sel), .e(e),
        .w(w1), .cur(cur1), .wrap(wrap1)
    );

    mux_scan_sel #(.CH(5), .DW(2), .DWELL(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .stb(stb), .mode(mode), .sel(sel5), .e(e5),
        .w(w5), .cur(cur5), .wrap(wrap5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        stb     = 1'b0;
        mode    = 1'b0;
        sel     = 4'd5;
        e       = 16'h0020;
        sel5    = 3'd2;
        e5      = 10'h020;

        // Reset held with active-looking inputs
        repeat (3) tick();
        check("rst_w", 32'(w), 32'h1);
        check("rst_cur", 32'(cur), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_w5", 32'(w5), 32'h3);

        stb   = 1'b1;
        rst_n = 1'b1;
        tick();
        check("rel_stb_w", 32'(w), 32'h1);
        check("rel_stb_cur", 32'(cur), 32'h0);

        // Direct select
        stb = 1'b0;
        tick();
        check("dir_w", 32'(w), 32'h0);
        check("dir_cur", 32'(cur), 32'h5);
        check("dir_w5", 32'(w5), 32'h1);
        check("dir_cur5", 32'(cur5), 32'h2);
        e    = 16'hFFDF;
        sel5 = 3'd6;
        tick();
        check("dir_w_cold", 32'(w), 32'h1);
        check("oor_w5", 32'(w5), 32'h3);
        check("oor_cur5", 32'(cur5), 32'h6);
        sel5 = 3'd4;
        e5   = 10'h100;
        tick();
        check("ch4_w5", 32'(w5), 32'h2);

        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            e   = 16'h0001 << s;
            tick();
            check("sweep_hot_w", 32'(w), 32'h0);
            check("sweep_cur", 32'(cur), 32'(s));
            e = ~(16'h0001 << s);
            tick();
            check("sweep_cold_w", 32'(w), 32'h1);
        end

        e = 16'h8000;
        tick();
        check("pre_async_w", 32'(w), 32'h0);
        #2 rst_n = 1'b0;
        #2;
        check("async_w", 32'(w), 32'h1);
        check("async_cur", 32'(cur), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_async_cur", 32'(cur), 32'hF);

`ifdef MUX_SCAN_SEL_SCAN_EN
        mode = 1'b1;
        e    = 16'h0001;
        for (int k = 1; k <= 65; k++) begin
            int ec;
            int ec1;
            tick();
            ec  = ((k - 1) / 4) % 16;
            ec1 = (k - 1) % 16;
            check("scan_cur", 32'(cur), 32'(ec));
            check("scan_w", 32'(w), (ec == 0) ? 32'h0 : 32'h1);
            check("scan_wrap", 32'(wrap), (k == 65) ? 32'h1 : 32'h0);
            check("scan1_cur", 32'(cur1), 32'(ec1));
            check("scan1_wrap", 32'(wrap1), (k > 1 && ec1 == 0) ? 32'h1 : 32'h0);
        end

        repeat (30) tick();
        check("pre_stb_cur", 32'(cur), 32'h7);
        stb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stb_w", 32'(w), 32'h1);
            check("stb_cur", 32'(cur), 32'h0);
            check("stb_wrap", 32'(wrap), 32'h0);
        end
        stb = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("post_stb_cur", 32'(cur), (k < 5) ? 32'h0 : 32'h1);
            check("post_stb_w", 32'(w), (k < 5) ? 32'h0 : 32'h1);
            check("post_stb_wrap", 32'(wrap), 32'h0);
        end

        repeat (32) tick();
        check("pre_sw_cur", 32'(cur), 32'h9);
        mode = 1'b0;
        sel  = 4'd3;
        e    = 16'h0008;
        tick();
        check("sw_cur", 32'(cur), 32'h3);
        check("sw_w", 32'(w), 32'h0);
        check("sw_wrap", 32'(wrap), 32'h0);
        mode = 1'b1;
        tick();
        check("reenter_cur", 32'(cur), 32'h0);
        check("reenter_w", 32'(w), 32'h1);
        check("reenter_wrap", 32'(wrap), 32'h0);
`else
        mode = 1'b1;
        sel  = 4'd12;
        e    = 16'hEFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("noscan_w", 32'(w), 32'h1);
            check("noscan_cur", 32'(cur), 32'hC);
            check("noscan_wrap", 32'(wrap), 32'h0);
            check("noscan_wrap1", 32'(wrap1), 32'h0);
        end
        e = 16'h1000;
        tick();
        check("noscan_hot_w", 32'(w), 32'h0);
        check("noscan_hot_cur", 32'(cur), 32'hC);
        stb = 1'b1;
        tick();
        check("noscan_stb_w", 32'(w), 32'h1);
        check("noscan_stb_cur", 32'(cur), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
